piso_serializer: RTL

- Parallel-in, serial-out transmitter; the sending end of the team's 8-bit serial-in shift-register link.
- Accepts a WIDTH-bit word through a ready/load handshake and shifts it out one bit per clock, LSB first.
- After WIDTH shifts, a downstream serial-in shift register that clocks in on sValid holds the word exactly: its Q equals pIn.
- Supports back-to-back words with no idle gap.

---
 rtl/piso_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter, LSB first, ready/load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pIn,
  input  logic             load,
  output logic             ready,
  output logic             sOut,
  output logic             sValid,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  // counter value loaded on accept; reaches 0 on the final frame bit
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SW - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;

  logic [SW-1:0]    frame;
  logic             last;
  logic             accept;
  logic             drop;
  logic             step;

`ifdef PISO_PARITY_EN
  assign frame = {^pIn, pIn};
`else
  assign frame = pIn;
`endif

  assign last   = (state_q == SHIFT) && (cnt_q == '0);
  assign ready  = !rst && ((state_q == IDLE) || last);
  assign accept = ready && load;
  assign drop   = last && !load;
  assign step   = (state_q == SHIFT) && !last;

  assign sOut   = sout_q;
  assign sValid = sval_q;
  assign done   = done_q;

  // next state, shift register and registered-output values
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b0;
    sval_d  = 1'b0;
    unique case (1'b1)
      accept: begin
        state_d = SHIFT;
        sh_d    = frame >> 1;
        sout_d  = frame[0];
        sval_d  = 1'b1;
        cnt_d   = LAST;
      end
      drop: begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
      step: begin
        sh_d   = sh_q >> 1;
        sout_d = sh_q[0];
        sval_d = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
    done_d = sval_d && (cnt_d == '0);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      sout_q <= 1'b0;
      sval_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      sout_q <= sout_d;
      sval_q <= sval_d;
      done_q <= done_d;
    end
  end

endmodule
